sram_port_arbiter: RTL
======================

# sram_port_arbiter

Two-requester arbiter and initialisation sequencer for a single-port, mask-writable, synchronous-read cache SRAM macro (RW0 style: one address, enable, write-mode, per-segment mask, 1-cycle registered read). It sits between the cache pipelines (requester 0: core access, requester 1: refill/writeback) and the SRAM. After reset it sweeps the array to zero, then grants the one port per cycle with round-robin fairness and returns read data one cycle after acceptance.

## Interface
- ADDR_W, 9, SRAM address width; depth = 2^ADDR_W
- DATA_W, 128, SRAM word width
- MASK_W, 4, write-mask segments; DATA_W divisible by MASK_W
- INIT_EN, 1, 1 = zero-sweep after reset, 0 = go straight to RUN

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- init_busy  out  1  high while the sweep is in progress
- pN_req_valid (N=0,1)  in  1  request present
- pN_req_ready  out  1  request accepted this cycle when valid && ready
- pN_req_write  in  1  1 = masked write, 0 = read
- pN_req_addr  in  ADDR_W  word address
- pN_req_wmask  in  MASK_W  segment enables, writes only
- pN_req_wdata  in  DATA_W  write data
- pN_resp_valid  out  1  read data valid, single cycle
- pN_resp_rdata  out  DATA_W  read data
- sram_en  out  1  to RW0_en
- sram_wmode  out  1  to RW0_wmode
- sram_addr  out  ADDR_W  to RW0_addr
- sram_wmask  out  MASK_W  to RW0_wmask
- sram_wdata  out  DATA_W  to RW0_wdata
- sram_rdata  in  DATA_W  from RW0_rdata

## Operation
- States: INIT, RUN. Reset enters INIT if INIT_EN=1, else RUN.
- INIT: counter init_addr (ADDR_W bits) starts at 0. Each cycle drives sram_en=1, wmode=1, addr=init_addr, wmask=all ones, wdata=0, then increments. On the cycle init_addr = 2^ADDR_W-1 is written, the next state is RUN. No wrap occurs. Both req_ready are 0 and init_busy=1 throughout.
- RUN: the grant is combinational from the valids and the round-robin pointer rr (1 bit, reset 0 = requester 0 preferred).
  - One valid: that requester is granted.
  - Both valid: requester rr is granted.
  - After any grant to N, rr becomes !N.
  - pN_req_ready = RUN && grant==N. Ready may depend on valid.
- On grant, the granted request drives the sram_* outputs directly with sram_en=1 and sram_wmode=req_write. With no grant, sram_en=0 and the other sram_* outputs are don't-care.
- Reads: a registered pending tag (valid + requester id) is set on a read acceptance. In the next cycle pN_resp_valid=1 for that id and pN_resp_rdata=sram_rdata. There is no response back-pressure and writes produce no response.
- A back-to-back read by the same requester yields resp_valid on consecutive cycles.
- Read-after-write to the same address in consecutive cycles returns the new data.
- resp_rdata of a non-responding port is don't-care. The bench checks it only when resp_valid=1.

## Timing
- Reset values: state per INIT_EN, init_addr=0, rr=0, pending=0, init_busy=INIT_EN, both resp_valid=0, both req_ready=0.
- Sweep takes exactly 2^ADDR_W cycles. If cycle 0 is the first rising edge after reset deassertion, the first request can be accepted in cycle 2^ADDR_W.
- Read latency: 1 cycle from the accept edge to resp_valid. Throughput is one access per cycle in total across both requesters.
- Starvation bound: a continuously valid requester is granted within 2 cycles.
- Reset mid-sweep or mid-read: pending is cleared with no spurious resp_valid, and the sweep restarts at address 0.

## Test plan
- Reset, then release: init_busy high for exactly 512 cycles, sram writes cover addresses 0..511 with mask 4'hF and data 0, and every address reads 0 afterwards.
- p0 writes 0xA5… to addr 3 with mask 4'b0101, then reads addr 3 -> resp_valid one cycle after accept, and only segments 0 and 2 are 0xA5.
- Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1, each read response is routed to the correct port, and there are no cross-port responses.
- p1 alone streams 4 reads to addresses 10..13 -> ready is high every cycle and resp_valid is high for 4 consecutive cycles with matching data.
- Reset asserted during a read accept and during the sweep at addr 200 -> no resp_valid, and the sweep restarts from 0.
- INIT_EN=0 -> init_busy=0, and a request in the first cycle after reset is accepted.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin arbiter and zero-sweep init sequencer for a
// single-port, mask-writable, synchronous-read (RW0 style) cache SRAM.
module sram_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 128,
    parameter int MASK_W  = 4,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [MASK_W-1:0] p0_req_wmask,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [MASK_W-1:0] p1_req_wmask,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,

    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [MASK_W-1:0] sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam state_t            RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] init_addr;
    logic              rr;
    logic              pend_valid;
    logic              pend_id;
    logic              grant_valid;
    logic              grant_id;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_addr == LAST_ADDR)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                // Contention goes to the rr-preferred side; a lone requester always wins.
                if (p0_req_valid && p1_req_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = rr;
                end else if (p0_req_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end else if (p1_req_valid) begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (state == ST_INIT) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = init_addr;
            sram_wmask = '1;
        end else if (grant_valid) begin
            sram_en    = 1'b1;
            sram_wmode = grant_id ? p1_req_write : p0_req_write;
            sram_addr  = grant_id ? p1_req_addr  : p0_req_addr;
            sram_wmask = grant_id ? p1_req_wmask : p0_req_wmask;
            sram_wdata = grant_id ? p1_req_wdata : p0_req_wdata;
        end
    end

    assign init_busy    = (state == ST_INIT);
    assign p0_req_ready = grant_valid && !grant_id;
    assign p1_req_ready = grant_valid &&  grant_id;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RESET_STATE;
            init_addr  <= '0;
            rr         <= 1'b0;
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_INIT)
                init_addr <= init_addr + ADDR_ONE;
            if (grant_valid)
                rr <= !grant_id;
            pend_valid <= grant_valid && !sram_wmode;
            pend_id    <= grant_id;
        end
    end

    // The macro's registered read lands exactly when the pending tag is live.
    assign p0_resp_valid = pend_valid && !pend_id;
    assign p1_resp_valid = pend_valid &&  pend_id;
    assign p0_resp_rdata = sram_rdata;
    assign p1_resp_rdata = sram_rdata;

endmodule
